// File: rtl/aes_pkg.sv
// Shared AES datapath types, byte-position helper and the InvSBOX lookup table.
package aes_pkg;

    localparam int unsigned AES_NBYTES = 16;

    typedef logic [8*AES_NBYTES-1:0] aes_state_t;
    typedef logic [7:0]              aes_byte_t;

    // Entry x lives at bits [2047-8x -: 8], i.e. byte 0x00 is the leftmost.
    localparam logic [2047:0] INV_SBOX_TABLE = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    function automatic int unsigned byte_idx(input int unsigned row, input int unsigned col);
        return 4 * col + row;
    endfunction

endpackage

// File: rtl/inv_sbox.sv
// Combinational AES inverse S-box lookup.
module inv_sbox
    import aes_pkg::*;
(
    input  aes_byte_t byte_val,
    output aes_byte_t sub_val
);

    // 8*(255-x) == {~x, 3'b000}
    assign sub_val = INV_SBOX_TABLE[{~byte_val, 3'b000} +: 8];

endmodule

// File: rtl/inv_sbox_lane.sv
// NSBOX parallel InvSBOX lookups applied to the chunk of the state selected by chunk.
module inv_sbox_lane
    import aes_pkg::*;
#(
    parameter int unsigned NSBOX = 4,
    parameter int unsigned CW    = 2
) (
    input  aes_state_t    state,
    input  logic [CW-1:0] chunk,
    output aes_state_t    state_next
);

    localparam int unsigned NCHUNK = AES_NBYTES / NSBOX;

    int unsigned base;
    aes_byte_t   lane_in  [NSBOX];
    aes_byte_t   lane_out [NSBOX];

    // With a single chunk the counter carries no information.
    assign base = (NCHUNK > 1) ? 32'(chunk) * NSBOX : 32'd0;

    for (genvar j = 0; j < NSBOX; j++) begin : g_lane
        assign lane_in[j] = state[8*(AES_NBYTES-1-(base+j)) +: 8];

        inv_sbox u_inv_sbox (
            .byte_val (lane_in[j]),
            .sub_val  (lane_out[j])
        );
    end

    always_comb begin
        state_next = state;
        for (int unsigned j = 0; j < NSBOX; j++) begin
            state_next[8*(AES_NBYTES-1-(base+j)) +: 8] = lane_out[j];
        end
    end

endmodule

// File: rtl/inv_sub_bytes_iter.sv
// Iterative InvSubBytes: NSBOX bytes per clock, 16/NSBOX cycles per block.
// Define INV_SHIFT_ROWS_EN to fold InvShiftRows into the input load.
module inv_sub_bytes_iter
    import aes_pkg::*;
#(
    parameter int unsigned NSBOX = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    localparam int unsigned NCHUNK = AES_NBYTES / NSBOX;
    localparam int unsigned CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    if (NSBOX != 1 && NSBOX != 2 && NSBOX != 4 && NSBOX != 8 && NSBOX != 16) begin : g_bad_nsbox
        $error("inv_sub_bytes_iter: NSBOX must be 1, 2, 4, 8 or 16");
    end

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    aes_state_t    work_q, work_d;
    aes_state_t    lane_next;
    aes_state_t    load_val;

`ifdef INV_SHIFT_ROWS_EN
    // Stored (row r, col c) takes input (row r, col (c-r) mod 4).
    always_comb begin
        load_val = '0;
        for (int unsigned r = 0; r < 4; r++) begin
            for (int unsigned c = 0; c < 4; c++) begin
                load_val[8*(AES_NBYTES-1-byte_idx(r, c)) +: 8] =
                    in_data[8*(AES_NBYTES-1-byte_idx(r, (c+4-r)%4)) +: 8];
            end
        end
    end
`else
    assign load_val = in_data;
`endif

    inv_sbox_lane #(
        .NSBOX (NSBOX),
        .CW    (CW)
    ) u_lane (
        .state      (work_q),
        .chunk      (cnt_q),
        .state_next (lane_next)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    work_d  = load_val;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                work_d = lane_next;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(NCHUNK - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign out_data  = work_q;

endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// Scoreboard bench for inv_sub_bytes_iter: directed NSBOX=4 checks plus NSBOX sweep instances.
module tb_inv_sub_bytes_iter;

    localparam logic [127:0] V_INC0 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] V_INC1 = 128'h101112131415161718191a1b1c1d1e1f;
`ifdef INV_SHIFT_ROWS_EN
    localparam logic [127:0] E_INC0 = 128'h52f3a3383009d79ebf366afb8140a5d5;
    localparam logic [127:0] E_INC1 = 128'h7cde43879be3e944342f39cbc48eff82;
`else
    localparam logic [127:0] E_INC0 = 128'h52096ad53036a538bf40a39e81f3d7fb;
    localparam logic [127:0] E_INC1 = 128'h7ce339829b2fff87348e4344c4dee9cb;
`endif
    localparam logic [127:0] ALL_63 = {16{8'h63}};
    localparam logic [127:0] ALL_00 = {16{8'h00}};
    localparam logic [127:0] ALL_52 = {16{8'h52}};
    localparam logic [127:0] ALL_FF = {16{8'hff}};
    localparam logic [127:0] ALL_7D = {16{8'h7d}};

    logic         clk = 1'b0;
    logic         rst_n, rst_s;
    logic         in_valid, in_ready, out_valid, out_ready, busy;
    logic [127:0] in_data, out_data;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [127:0] exp_q[$];
    int           acc_q[$];
    bit           sweep_done [4];

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    inv_sub_bytes_iter #(.NSBOX(4)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference InvSBOX from GF(2^8) arithmetic, independent of any lookup table.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] inv_sbox_ref(input logic [7:0] v);
        logic [7:0] s;
        logic [7:0] r = 8'h01;
        s = {v[6:0], v[7]} ^ {v[4:0], v[7:5]} ^ {v[1:0], v[7:2]} ^ 8'h05;
        for (int i = 0; i < 254; i++) r = gmul(r, s);
        return r;
    endfunction

    function automatic logic [127:0] ref_block(input logic [127:0] d);
        logic [127:0] s;
        logic [127:0] o;
        s = d;
`ifdef INV_SHIFT_ROWS_EN
        for (int i = 0; i < 16; i++) begin
            int src;
            src = 4 * (((i / 4) + 4 - (i % 4)) % 4) + (i % 4);
            s[127-8*i -: 8] = d[127-8*src -: 8];
        end
`endif
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = inv_sbox_ref(s[127-8*i -: 8]);
        return o;
    endfunction

    task automatic wait_accept(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk(name, ok, 1);
    endtask

    task automatic send(input logic [127:0] d, input logic [127:0] e, input string name);
        @(posedge clk); #1;
        exp_q.push_back(e);
        in_valid = 1'b1;
        in_data  = d;
        wait_accept(name);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk(name, ok, 1);
    endtask

    // Monitor for the NSBOX=4 instance: latency on out_valid rise, data on handshake.
    initial begin
        bit ovp = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                ovp = 1'b0;
            end else begin
                if (in_valid && in_ready) acc_q.push_back(cyc + 1);
                if (out_valid && !ovp)
                    chk("latency4", (acc_q.size() != 0) ? cyc - acc_q.pop_front() : -1, 4);
                if (out_valid && out_ready)
                    chk("data4", out_data, (exp_q.size() != 0) ? exp_q.pop_front() : 'x);
                ovp = out_valid;
            end
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_sweep
        localparam int unsigned NS  = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 8 : 16;
        localparam int          NCH = 16 / NS;

        logic         iv, ir, ov, orr, bz;
        logic [127:0] id, od;
        logic [127:0] eq[$];
        int           aq[$];

        inv_sub_bytes_iter #(.NSBOX(NS)) u_dut (
            .clk       (clk),
            .rst_n     (rst_s),
            .in_valid  (iv),
            .in_ready  (ir),
            .in_data   (id),
            .out_valid (ov),
            .out_ready (orr),
            .out_data  (od),
            .busy      (bz)
        );

        initial begin
            orr = 1'b1;
            forever begin
                @(posedge clk); #1;
                orr = ($urandom_range(0, 3) != 0);
            end
        end

        initial begin
            iv = 1'b0;
            id = '0;
            sweep_done[g] = 1'b0;
            wait (rst_s === 1'b1);
            for (int n = 0; n < 200; n++) begin
                logic [127:0] d;
                bit           ok;
                d = {$urandom(), $urandom(), $urandom(), $urandom()};
                @(posedge clk); #1;
                eq.push_back(ref_block(d));
                iv = 1'b1;
                id = d;
                ok = 1'b0;
                for (int i = 0; i < 100; i++) begin
                    @(negedge clk);
                    if (ir) begin
                        ok = 1'b1;
                        break;
                    end
                end
                chk($sformatf("sweep%0d_accept", NS), ok, 1);
                @(posedge clk); #1;
                iv = 1'b0;
            end
            for (int i = 0; i < 200 && eq.size() != 0; i++) @(negedge clk);
            chk($sformatf("sweep%0d_drain", NS), eq.size(), 0);
            sweep_done[g] = 1'b1;
        end

        initial begin
            bit ovp = 1'b0;
            forever begin
                @(negedge clk);
                if (!rst_s) begin
                    ovp = 1'b0;
                end else begin
                    if (iv && ir) aq.push_back(cyc + 1);
                    if (ov && !ovp)
                        chk($sformatf("sweep%0d_latency", NS),
                            (aq.size() != 0) ? cyc - aq.pop_front() : -1, NCH);
                    if (ov && orr)
                        chk($sformatf("sweep%0d_data", NS), od,
                            (eq.size() != 0) ? eq.pop_front() : 'x);
                    ovp = ov;
                end
            end
        end
    end

    initial begin
        bit ok;
        rst_n     = 1'b0;
        rst_s     = 1'b0;
        in_valid  = 1'b0;
        in_data   = ALL_FF;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        rst_s = 1'b1;

        send(ALL_63, ALL_00, "accept_63");
        drain("drain_63");
        send(V_INC0, E_INC0, "accept_inc0");
        drain("drain_inc0");
        send(V_INC1, E_INC1, "accept_inc1");
        drain("drain_inc1");

        // Backpressure in DONE with in_valid held high and a new block waiting on in_data.
        @(posedge clk); #1;
        out_ready = 1'b0;
        exp_q.push_back(ALL_52);
        in_valid = 1'b1;
        in_data  = ALL_00;
        wait_accept("bp_accept_a");
        @(posedge clk); #1;
        in_data = ALL_63;
        exp_q.push_back(ALL_00);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        chk("bp_out_valid_rise", ok, 1);
        for (int i = 0; i < 10; i++) begin
            chk("bp_out_valid", out_valid, 1);
            chk("bp_out_data", out_data, ALL_52);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_busy", busy, 1);
            @(negedge clk);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_accept("bp_accept_b");
        @(posedge clk); #1;
        in_valid = 1'b0;
        drain("drain_bp");

        // Reset while RUN is on chunk 2: the block is discarded.
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = V_INC0;
        wait_accept("mid_accept");
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        chk("mid_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_out_valid", out_valid, 0);
        chk("mid_in_ready", in_ready, 1);
        chk("mid_out_data", out_data, 0);
        chk("mid_busy", busy, 0);
        acc_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        send(ALL_FF, ALL_7D, "accept_ff");
        drain("drain_ff");

        ok = 1'b0;
        for (int i = 0; i < 30000; i++) begin
            if (sweep_done[0] && sweep_done[1] && sweep_done[2] && sweep_done[3]) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("sweep_complete", ok, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
